kab_eic_arbiter: RTL and testbench

//  External interrupt controller feeding the Kabeta core's EIC_IntReq/EIC_IntId/EIC_IntAck handshake.

---
 rtl/kab_eic_arbiter.sv | 154 +++++++++++++++
 tb/tb_kab_eic_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/kab_eic_arbiter.sv
// kab_eic_arbiter: external interrupt controller for the core's EIC handshake.
// It turns rising edges on the Src_Irq lines into pending bits and applies a software mask.
// It then picks one enabled pending source, either by fixed priority or round-robin,
// and holds its ID on EIC_IntId until the core acknowledges it.
//
// Ports:
//   Sys_Clock, Sys_Reset       clock and synchronous active-high reset
//   Src_Irq[NUM_SRC]           synchronous interrupt lines, rising edge = event
//   Reg_WrEn/RdEn/Addr/WrData  register port: 0=MASK 1=PENDING(W1C) 2=STATUS 3=reserved
//   Reg_RdData                 registered read data, updated only when Reg_RdEn=1
//   EIC_IntReq/IntId/IntAck    request/ID/acknowledge handshake with the core
module kab_eic_arbiter #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned RR_MODE = 1
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Src_Irq,
  input  logic               Reg_WrEn,
  input  logic               Reg_RdEn,
  input  logic [1:0]         Reg_Addr,
  input  logic [31:0]        Reg_WrData,
  output logic [31:0]        Reg_RdData,
  output logic               EIC_IntReq,
  output logic [ID_W-1:0]    EIC_IntId,
  input  logic               EIC_IntAck
);

  typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  src_prev_q;
  logic                int_req_q, int_req_d;
  logic [ID_W-1:0]     int_id_q, int_id_d;
  logic [ID_W-1:0]     rr_last_q, rr_last_d;
  logic [31:0]         rd_data_q, rd_data_d;

  logic [NUM_SRC-1:0]  cand;
  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  w1c;
  logic [NUM_SRC-1:0]  ack_clr;
  logic [ID_W-1:0]     sel_id;
  logic                found;
  int unsigned         idx;
  logic [31:0]         rd_val;
  logic                unused_wr_bits;

  // Upper write-data bits are ignored when NUM_SRC < 32.
  assign unused_wr_bits = ^Reg_WrData;

  assign cand = pending_q & mask_q;
  assign rise = Src_Irq & ~src_prev_q;

  // Source selection from this cycle's candidates.
  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (RR_MODE == 0) begin
      // Descending scan so the lowest set index is the last to write.
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
        if (cand[i]) sel_id = ID_W'(i);
      end
    end else begin
      // Search rr_last+1, rr_last+2, ... wrapping; rr_last itself comes last.
      for (int k = 1; k <= int'(NUM_SRC); k++) begin
        idx = (int'(rr_last_q) + k) % NUM_SRC;
        if (!found && cand[idx]) begin
          sel_id = ID_W'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  // Handshake FSM.
  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    int_id_d  = int_id_q;
    rr_last_d = rr_last_q;
    ack_clr   = '0;
    case (state_q)
      StIdle: begin
        if (|cand) begin
          state_d   = StReq;
          int_req_d = 1'b1;
          int_id_d  = sel_id;
        end
      end
      StReq: begin
        // Request is held even if its source is masked or cleared meanwhile.
        if (EIC_IntAck) begin
          ack_clr   = NUM_SRC'(1) << int_id_q;
          rr_last_d = int_id_q;
          int_req_d = 1'b0;
          state_d   = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Register port and pending update; a new edge wins over any clear in the same cycle.
  always_comb begin
    w1c    = (Reg_WrEn && Reg_Addr == 2'd1) ? Reg_WrData[NUM_SRC-1:0] : '0;
    mask_d = (Reg_WrEn && Reg_Addr == 2'd0) ? Reg_WrData[NUM_SRC-1:0] : mask_q;
    pending_d = (pending_q & ~ack_clr & ~w1c) | rise;

    rd_val = '0;
    case (Reg_Addr)
      2'd0: rd_val = 32'(mask_q);
      2'd1: rd_val = 32'(pending_q);
      2'd2: begin
        rd_val[ID_W-1:0] = int_id_q;
        rd_val[31]       = int_req_q;
      end
      default: rd_val = '0;
    endcase
    // Reads sample pre-write register values.
    rd_data_d = Reg_RdEn ? rd_val : rd_data_q;
  end

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      pending_q  <= '0;
      src_prev_q <= '0;
      int_req_q  <= 1'b0;
      int_id_q   <= '0;
      rr_last_q  <= ID_W'(NUM_SRC - 1);
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      src_prev_q <= Src_Irq;
      int_req_q  <= int_req_d;
      int_id_q   <= int_id_d;
      rr_last_q  <= rr_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign EIC_IntReq = int_req_q;
  assign EIC_IntId  = int_id_q;
  assign Reg_RdData = rd_data_q;

endmodule

// File: tb/tb_kab_eic_arbiter.sv
// Directed bench for kab_eic_arbiter. Two instances share all inputs:
// dut_a uses round-robin, dut_b fixed priority.
module tb_kab_eic_arbiter;

  logic        clk;
  logic        rst;
  logic [7:0]  irq;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic        ack;
  logic [31:0] rd_data_a, rd_data_b;
  logic        req_a, req_b;
  logic [2:0]  id_a, id_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;
  int exp_a [3] = '{5, 1, 1};

  kab_eic_arbiter #(.NUM_SRC(8), .ID_W(3), .RR_MODE(1)) dut_a (
    .Sys_Clock (clk),
    .Sys_Reset (rst),
    .Src_Irq   (irq),
    .Reg_WrEn  (wr_en),
    .Reg_RdEn  (rd_en),
    .Reg_Addr  (addr),
    .Reg_WrData(wr_data),
    .Reg_RdData(rd_data_a),
    .EIC_IntReq(req_a),
    .EIC_IntId (id_a),
    .EIC_IntAck(ack)
  );

  kab_eic_arbiter #(.NUM_SRC(8), .ID_W(3), .RR_MODE(0)) dut_b (
    .Sys_Clock (clk),
    .Sys_Reset (rst),
    .Src_Irq   (irq),
    .Reg_WrEn  (wr_en),
    .Reg_RdEn  (rd_en),
    .Reg_Addr  (addr),
    .Reg_WrData(wr_data),
    .Reg_RdData(rd_data_b),
    .EIC_IntReq(req_b),
    .EIC_IntId (id_b),
    .EIC_IntAck(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick();
    wr_en = 1'b0; wr_data = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    d = rd_data_a;
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    irq = m;
    tick();
    irq = '0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; wr_en = 0; rd_en = 0; addr = '0; wr_data = '0; ack = 0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state, basic latency, ack
    check("rst_req", {31'd0, req_a}, 32'd0);
    check("rst_id", {29'd0, id_a}, 32'd0);
    check("rst_rd_b", rd_data_b, 32'd0);
    reg_read(2'd0, rd); check("rst_mask", rd, 32'd0);
    reg_write(2'd0, 32'hFF);
    pulse_irq(8'h08);
    check("t1_req_edge1", {31'd0, req_a}, 32'd0);
    tick();
    check("t1_req_edge2", {31'd0, req_a}, 32'd1);
    check("t1_id", {29'd0, id_a}, 32'd3);
    ack_pulse();
    check("t1_req_after_ack", {31'd0, req_a}, 32'd0);
    reg_read(2'd1, rd); check("t1_pending", rd, 32'h00);

    // 2a: round-robin 1 then 5, refire both wraps back to 1
    do_reset();
    reg_write(2'd0, 32'hFF);
    for (int r = 0; r < 2; r++) begin
      pulse_irq(8'h22);
      tick();
      check("t2_first_id", {29'd0, id_a}, 32'd1);
      check("t2_first_req", {31'd0, req_a}, 32'd1);
      ack_pulse(); tick(); tick();
      check("t2_second_id", {29'd0, id_a}, 32'd5);
      ack_pulse(); tick(); tick();
      check("t2_idle", {31'd0, req_a}, 32'd0);
    end

    // 2b: 1 and 5 pending, 1 refired after each ack
    do_reset();
    reg_write(2'd0, 32'hFF);
    pulse_irq(8'h22);
    tick();
    check("t2b_first_b", {29'd0, id_b}, 32'd1);
    for (int r = 0; r < 3; r++) begin
      ack_pulse();
      pulse_irq(8'h02);
      tick();
      check("t2b_fixed_id", {29'd0, id_b}, 32'd1);
      check("t2b_rr_id", {29'd0, id_a}, exp_a[r]);
    end

    // 3: masked source still pends; unmask raises request
    do_reset();
    reg_write(2'd0, 32'h00);
    pulse_irq(8'h04);
    tick();
    check("t3_req_masked", {31'd0, req_a}, 32'd0);
    reg_read(2'd1, rd); check("t3_pending", rd, 32'h04);
    reg_write(2'd0, 32'h04);
    check("t3_req_after_write", {31'd0, req_a}, 32'd0);
    tick();
    check("t3_req", {31'd0, req_a}, 32'd1);
    check("t3_id", {29'd0, id_a}, 32'd2);

    // 4: W1C and mask-off during REQ do not drop the request
    do_reset();
    reg_write(2'd0, 32'hFF);
    pulse_irq(8'h10);
    tick();
    check("t4_id", {29'd0, id_a}, 32'd4);
    reg_write(2'd1, 32'h10);
    reg_write(2'd0, 32'h00);
    check("t4_req_held", {31'd0, req_a}, 32'd1);
    check("t4_id_held", {29'd0, id_a}, 32'd4);
    reg_read(2'd1, rd); check("t4_pending", rd, 32'h00);
    reg_read(2'd2, rd); check("t4_status", rd, 32'h8000_0004);
    ack_pulse(); tick(); tick();
    check("t4_stays_idle", {31'd0, req_a}, 32'd0);

    // 5: ack and new edge on the same source; set wins
    do_reset();
    reg_write(2'd0, 32'hFF);
    pulse_irq(8'h40);
    tick();
    check("t5_id", {29'd0, id_a}, 32'd6);
    ack = 1'b1; irq = 8'h40;
    tick();
    ack = 1'b0; irq = '0;
    check("t5_gap", {31'd0, req_a}, 32'd0);
    reg_read(2'd1, rd); check("t5_pending", rd, 32'h40);
    tick();
    check("t5_req_again", {31'd0, req_a}, 32'd1);
    check("t5_id_again", {29'd0, id_a}, 32'd6);

    // 6: reset mid-handshake; late ack ignored
    do_reset();
    check("t6_req", {31'd0, req_a}, 32'd0);
    check("t6_rd_cleared", rd_data_a, 32'd0);
    ack_pulse();
    check("t6_late_ack", {31'd0, req_a}, 32'd0);
    reg_read(2'd2, rd); check("t6_status", rd, 32'd0);
    reg_read(2'd1, rd); check("t6_pending", rd, 32'd0);
    reg_read(2'd0, rd); check("t6_mask", rd, 32'd0);

    // Register corner cases
    reg_write(2'd0, 32'hFFFF_FFFF);
    reg_read(2'd0, rd); check("mask_upper_bits", rd, 32'hFF);
    reg_write(2'd3, 32'h1234_5678);
    reg_read(2'd3, rd); check("addr3_read", rd, 32'd0);
    wr_en = 1'b1; rd_en = 1'b1; addr = 2'd0; wr_data = 32'h0F;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rdwr_prewrite", rd_data_a, 32'hFF);
    tick();
    check("rd_holds", rd_data_a, 32'hFF);
    reg_read(2'd0, rd); check("rdwr_postwrite", rd, 32'h0F);

    // A held-high level is a single event
    do_reset();
    reg_write(2'd0, 32'h01);
    irq = 8'h01;
    tick(); tick();
    check("level_req", {31'd0, req_a}, 32'd1);
    check("level_id", {29'd0, id_a}, 32'd0);
    ack_pulse(); tick(); tick(); tick();
    check("level_once", {31'd0, req_a}, 32'd0);
    irq = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
